// File: rtl/hdc_pkg.sv
// Shared FSM states, slot indices and channel geometry for the HDC SRAM loader.
// Channel counts and widths default here unless the build defines them first.
`ifndef HV_DIMENSION
`define HV_DIMENSION 40
`endif
`ifndef GSR_NUM_CHANNEL
`define GSR_NUM_CHANNEL 3
`endif
`ifndef ECG_NUM_CHANNEL
`define ECG_NUM_CHANNEL 6
`endif
`ifndef EEG_NUM_CHANNEL
`define EEG_NUM_CHANNEL 7
`endif
`ifndef GSR_SRAM_ADDR_WIDTH
`define GSR_SRAM_ADDR_WIDTH 2
`endif
`ifndef ECG_SRAM_ADDR_WIDTH
`define ECG_SRAM_ADDR_WIDTH 3
`endif
`ifndef EEG_SRAM_ADDR_WIDTH
`define EEG_SRAM_ADDR_WIDTH 3
`endif

package hdc_pkg;
    localparam int HV_W      = `HV_DIMENSION;
    localparam int GSR_CH    = `GSR_NUM_CHANNEL;
    localparam int ECG_CH    = `ECG_NUM_CHANNEL;
    localparam int EEG_CH    = `EEG_NUM_CHANNEL;
    localparam int GSR_AW    = `GSR_SRAM_ADDR_WIDTH;
    localparam int ECG_AW    = `ECG_SRAM_ADDR_WIDTH;
    localparam int EEG_AW    = `EEG_SRAM_ADDR_WIDTH;
    localparam int NUM_SLOTS = 9;
    localparam int SLOT_W    = 4;
    localparam int ROW_W     = (EEG_CH > 1) ? $clog2(EEG_CH) : 1;

    localparam logic [SLOT_W-1:0] SLOT_GSR_IM  = 4'd0;
    localparam logic [SLOT_W-1:0] SLOT_GSR_POS = 4'd1;
    localparam logic [SLOT_W-1:0] SLOT_GSR_NEG = 4'd2;
    localparam logic [SLOT_W-1:0] SLOT_ECG_IM  = 4'd3;
    localparam logic [SLOT_W-1:0] SLOT_ECG_POS = 4'd4;
    localparam logic [SLOT_W-1:0] SLOT_ECG_NEG = 4'd5;
    localparam logic [SLOT_W-1:0] SLOT_EEG_IM  = 4'd6;
    localparam logic [SLOT_W-1:0] SLOT_EEG_POS = 4'd7;
    localparam logic [SLOT_W-1:0] SLOT_EEG_NEG = 4'd8;

    typedef enum logic [2:0] {IDLE, COLLECT, ROW_WR, COMMIT, DONE} state_e;

    function automatic int mod_channels(input int slot);
        if (slot < 3) return GSR_CH;
        if (slot < 6) return ECG_CH;
        return EEG_CH;
    endfunction

    function automatic logic slot_active(input logic [ROW_W-1:0] r, input int slot);
        return int'(r) < mod_channels(slot);
    endfunction

    // EEG has the most channels, so every row owns at least the EEG slots.
    function automatic logic [SLOT_W-1:0] first_slot(input logic [ROW_W-1:0] r);
        if (slot_active(r, 0)) return SLOT_GSR_IM;
        if (slot_active(r, 3)) return SLOT_ECG_IM;
        return SLOT_EEG_IM;
    endfunction

`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
    // Bit i lands in lane i%16: same as XOR of zero-padded 16-bit chunks.
    function automatic logic [15:0] fold16(input logic [HV_W-1:0] v);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < HV_W; i++) c[i % 16] = c[i % 16] ^ v[i];
        return c;
    endfunction
`endif
endpackage

// File: rtl/hdc_slot_sequencer.sv
// Walks the 9 slots of a row, skipping modalities whose channels are exhausted.
module hdc_slot_sequencer
    import hdc_pkg::*;
(
    input  logic [ROW_W-1:0]  r_i,
    input  logic [SLOT_W-1:0] s_i,
    output logic [SLOT_W-1:0] nxt_slot_o,
    output logic              row_last_o,
    output logic              load_last_o
);
    always_comb begin
        nxt_slot_o = s_i;
        row_last_o = 1'b1;
        // Descending scan so the lowest active slot above s_i wins.
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            if (k > int'(s_i) && slot_active(r_i, k)) begin
                nxt_slot_o = SLOT_W'(k);
                row_last_o = 1'b0;
            end
        end
        load_last_o = row_last_o && (int'(r_i) == EEG_CH - 1);
    end
endmodule

// File: rtl/hdc_sram_loader.sv
// Streams hypervector beats into per-slot staging, presents one SRAM row per
// ROW_WR cycle, then commits. Optional checksum: HDC_SRAM_LOADER_CHECKSUM_EN.
module hdc_sram_loader
    import hdc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HV_W-1:0]   hv_in,
    input  logic              hv_in_valid,
    output logic              hv_in_ready,
    output logic              load_done,
    output logic              write_enable,
    output logic              write_enable_valid,
    output logic [GSR_AW-1:0] FPGA_GSR_im_sram_addr,
    output logic [GSR_AW-1:0] FPGA_GSR_projm_pos_sram_addr,
    output logic [GSR_AW-1:0] FPGA_GSR_projm_neg_sram_addr,
    output logic [HV_W-1:0]   FPGA_GSR_im_sram_hvin,
    output logic [HV_W-1:0]   FPGA_GSR_projm_pos_sram_hvin,
    output logic [HV_W-1:0]   FPGA_GSR_projm_neg_sram_hvin,
    output logic [ECG_AW-1:0] FPGA_ECG_im_sram_addr,
    output logic [ECG_AW-1:0] FPGA_ECG_projm_pos_sram_addr,
    output logic [ECG_AW-1:0] FPGA_ECG_projm_neg_sram_addr,
    output logic [HV_W-1:0]   FPGA_ECG_im_sram_hvin,
    output logic [HV_W-1:0]   FPGA_ECG_projm_pos_sram_hvin,
    output logic [HV_W-1:0]   FPGA_ECG_projm_neg_sram_hvin,
    output logic [EEG_AW-1:0] FPGA_EEG_im_sram_addr,
    output logic [EEG_AW-1:0] FPGA_EEG_projm_pos_sram_addr,
    output logic [EEG_AW-1:0] FPGA_EEG_projm_neg_sram_addr,
    output logic [HV_W-1:0]   FPGA_EEG_im_sram_hvin,
    output logic [HV_W-1:0]   FPGA_EEG_projm_pos_sram_hvin,
    output logic [HV_W-1:0]   FPGA_EEG_projm_neg_sram_hvin
`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);
    state_e                           state_q, state_d;
    logic [ROW_W-1:0]                 r_q, r_d;
    logic [SLOT_W-1:0]                s_q, s_d;
    logic [NUM_SLOTS-1:0][HV_W-1:0]   stg_q;
    logic [GSR_AW-1:0]                gsr_addr_q;
    logic [ECG_AW-1:0]                ecg_addr_q;
    logic [EEG_AW-1:0]                eeg_addr_q;
    logic [SLOT_W-1:0]                nxt_slot;
    logic                             row_last, load_last, accept, row_end;

    hdc_slot_sequencer u_seq (
        .r_i         (r_q),
        .s_i         (s_q),
        .nxt_slot_o  (nxt_slot),
        .row_last_o  (row_last),
        .load_last_o (load_last)
    );

    assign hv_in_ready        = (state_q == COLLECT);
    assign accept             = hv_in_valid && hv_in_ready;
    assign row_end            = accept && row_last;
    assign write_enable_valid = (state_q == COLLECT) || (state_q == ROW_WR) || (state_q == COMMIT);
    assign write_enable       = (state_q == COMMIT);
    assign load_done          = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        s_d     = s_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = COLLECT;
                r_d     = '0;
                s_d     = first_slot('0);
            end
            COLLECT: if (accept) begin
                if (row_last) state_d = ROW_WR;
                else          s_d     = nxt_slot;
            end
            ROW_WR: if (load_last) begin
                state_d = COMMIT;
            end else begin
                state_d = COLLECT;
                r_d     = r_q + 1'b1;
                s_d     = first_slot(r_q + 1'b1);
            end
            COMMIT:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses latch r on the row's last beat so they read r during ROW_WR;
    // exhausted modalities keep their final row address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            s_q        <= '0;
            stg_q      <= '0;
            gsr_addr_q <= '0;
            ecg_addr_q <= '0;
            eeg_addr_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            s_q     <= s_d;
            if (accept) stg_q[s_q] <= hv_in;
            if (row_end && slot_active(r_q, 0)) gsr_addr_q <= GSR_AW'(r_q);
            if (row_end && slot_active(r_q, 3)) ecg_addr_q <= ECG_AW'(r_q);
            if (row_end && slot_active(r_q, 6)) eeg_addr_q <= EEG_AW'(r_q);
        end
    end

    assign FPGA_GSR_im_sram_addr        = gsr_addr_q;
    assign FPGA_GSR_projm_pos_sram_addr = gsr_addr_q;
    assign FPGA_GSR_projm_neg_sram_addr = gsr_addr_q;
    assign FPGA_ECG_im_sram_addr        = ecg_addr_q;
    assign FPGA_ECG_projm_pos_sram_addr = ecg_addr_q;
    assign FPGA_ECG_projm_neg_sram_addr = ecg_addr_q;
    assign FPGA_EEG_im_sram_addr        = eeg_addr_q;
    assign FPGA_EEG_projm_pos_sram_addr = eeg_addr_q;
    assign FPGA_EEG_projm_neg_sram_addr = eeg_addr_q;

    assign FPGA_GSR_im_sram_hvin        = stg_q[SLOT_GSR_IM];
    assign FPGA_GSR_projm_pos_sram_hvin = stg_q[SLOT_GSR_POS];
    assign FPGA_GSR_projm_neg_sram_hvin = stg_q[SLOT_GSR_NEG];
    assign FPGA_ECG_im_sram_hvin        = stg_q[SLOT_ECG_IM];
    assign FPGA_ECG_projm_pos_sram_hvin = stg_q[SLOT_ECG_POS];
    assign FPGA_ECG_projm_neg_sram_hvin = stg_q[SLOT_ECG_NEG];
    assign FPGA_EEG_im_sram_hvin        = stg_q[SLOT_EEG_IM];
    assign FPGA_EEG_projm_pos_sram_hvin = stg_q[SLOT_EEG_POS];
    assign FPGA_EEG_projm_neg_sram_hvin = stg_q[SLOT_EEG_NEG];

`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk) begin
        if (rst)                                                 csum_q <= '0;
        else if ((state_q == IDLE || state_q == DONE) && start) csum_q <= '0;
        else if (accept)                                         csum_q <= csum_q ^ fold16(hv_in);
    end

    assign checksum = csum_q;
`endif
endmodule

// File: tb/tb_hdc_sram_loader.sv
// Randomized bench for hdc_sram_loader against a row/slot reference model.
module tb_hdc_sram_loader;
    import hdc_pkg::*;

    localparam int TOTAL = 3 * (GSR_CH + ECG_CH + EEG_CH);
    localparam int PADW  = ((HV_W + 15) / 16) * 16;

    logic clk = 1'b0;
    logic rst, start, hv_in_valid, hv_in_ready, load_done, write_enable, write_enable_valid;
    logic [HV_W-1:0] hv_in;
    logic [GSR_AW-1:0] g_im_a, g_pos_a, g_neg_a;
    logic [ECG_AW-1:0] c_im_a, c_pos_a, c_neg_a;
    logic [EEG_AW-1:0] e_im_a, e_pos_a, e_neg_a;
    logic [HV_W-1:0] g_im_h, g_pos_h, g_neg_h, c_im_h, c_pos_h, c_neg_h, e_im_h, e_pos_h, e_neg_h;
`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    hdc_sram_loader dut (
        .clk(clk), .rst(rst), .start(start), .hv_in(hv_in), .hv_in_valid(hv_in_valid),
        .hv_in_ready(hv_in_ready), .load_done(load_done), .write_enable(write_enable),
        .write_enable_valid(write_enable_valid),
        .FPGA_GSR_im_sram_addr(g_im_a), .FPGA_GSR_projm_pos_sram_addr(g_pos_a), .FPGA_GSR_projm_neg_sram_addr(g_neg_a),
        .FPGA_GSR_im_sram_hvin(g_im_h), .FPGA_GSR_projm_pos_sram_hvin(g_pos_h), .FPGA_GSR_projm_neg_sram_hvin(g_neg_h),
        .FPGA_ECG_im_sram_addr(c_im_a), .FPGA_ECG_projm_pos_sram_addr(c_pos_a), .FPGA_ECG_projm_neg_sram_addr(c_neg_a),
        .FPGA_ECG_im_sram_hvin(c_im_h), .FPGA_ECG_projm_pos_sram_hvin(c_pos_h), .FPGA_ECG_projm_neg_sram_hvin(c_neg_h),
        .FPGA_EEG_im_sram_addr(e_im_a), .FPGA_EEG_projm_pos_sram_addr(e_pos_a), .FPGA_EEG_projm_neg_sram_addr(e_neg_a),
        .FPGA_EEG_im_sram_hvin(e_im_h), .FPGA_EEG_projm_pos_sram_hvin(e_pos_h), .FPGA_EEG_projm_neg_sram_hvin(e_neg_h)
`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int chans[3] = '{GSR_CH, ECG_CH, EEG_CH};
    logic [HV_W-1:0] sent[$];
    logic [8:0][7:0] row_addr_q[$];
    logic [8:0][HV_W-1:0] row_hv_q[$];
    int row_beats[$];
    int cur_beats, we_cnt, wev_cnt;
    logic [8:0][7:0] mon_a;
    logic [8:0][HV_W-1:0] mon_h;

    // A ROW_WR cycle is the only one with valid-but-not-writing and ready low.
    always @(negedge clk) begin
        if (hv_in_valid && hv_in_ready) cur_beats++;
        if (write_enable_valid && !write_enable && !hv_in_ready) begin
            mon_a = {8'(e_neg_a), 8'(e_pos_a), 8'(e_im_a), 8'(c_neg_a), 8'(c_pos_a), 8'(c_im_a),
                     8'(g_neg_a), 8'(g_pos_a), 8'(g_im_a)};
            mon_h = {e_neg_h, e_pos_h, e_im_h, c_neg_h, c_pos_h, c_im_h, g_neg_h, g_pos_h, g_im_h};
            row_addr_q.push_back(mon_a);
            row_hv_q.push_back(mon_h);
            row_beats.push_back(cur_beats);
            cur_beats = 0;
        end
        if (write_enable) we_cnt++;
        if (write_enable_valid) wev_cnt++;
    end

    task automatic clear_mon();
        sent.delete(); row_addr_q.delete(); row_hv_q.delete(); row_beats.delete();
        cur_beats = 0; we_cnt = 0; wev_cnt = 0;
    endtask

    function automatic logic [HV_W-1:0] rand_hv();
        logic [HV_W-1:0] v;
        for (int i = 0; i < HV_W; i++) v[i] = 1'($urandom_range(1, 0));
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic drive_beats(input int n, input int maxgap, input bit ones);
        for (int i = 0; i < n; i++) begin
            logic [HV_W-1:0] v;
            int g, wt;
            v = ones ? '1 : rand_hv();
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            if (g > 0) begin
                hv_in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            hv_in = v; hv_in_valid = 1'b1; sent.push_back(v);
            wt = 0;
            while (!hv_in_ready && wt < 20) begin @(posedge clk); #1; wt++; end
            if (!hv_in_ready) begin
                n_cmp++; n_err++;
                $display("FAIL beat_wait: ready got %b want 1 at beat %0d", hv_in_ready, i);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag);
        int wt = 0;
        while (load_done !== 1'b1 && wt < 100) begin @(posedge clk); #1; wt++; end
        n_cmp++;
        if (load_done !== 1'b1) begin n_err++; $display("FAIL %s_done: load_done got %b want 1", tag, load_done); end
    endtask

    // Model: beats fill active slots in order; exhausted modalities hold their last row.
    task automatic check_load(input string tag);
        int idx = 0;
        int ea[9];
        logic [HV_W-1:0] eh[9];
        for (int k = 0; k < 9; k++) begin ea[k] = 0; eh[k] = '0; end
        n_cmp++;
        if (row_addr_q.size() != EEG_CH) begin
            n_err++; $display("FAIL %s_rows: got %0d want %0d", tag, row_addr_q.size(), EEG_CH);
        end
        n_cmp++;
        if (we_cnt !== 1) begin n_err++; $display("FAIL %s_commit: got %0d want 1", tag, we_cnt); end
        for (int r = 0; r < EEG_CH && r < row_addr_q.size(); r++) begin
            int act = 0;
            for (int sl = 0; sl < 9; sl++)
                if (r < chans[sl / 3] && idx < sent.size()) begin
                    ea[sl] = r; eh[sl] = sent[idx]; idx++; act++;
                end
            n_cmp++;
            if (row_beats[r] !== act) begin
                n_err++; $display("FAIL %s_beats r%0d: got %0d want %0d", tag, r, row_beats[r], act);
            end
            for (int sl = 0; sl < 9; sl++) begin
                n_cmp++;
                if (row_addr_q[r][sl] !== 8'(ea[sl]) || row_hv_q[r][sl] !== eh[sl]) begin
                    n_err++;
                    $display("FAIL %s_write r%0d s%0d: got a=%0d hv=%h want a=%0d hv=%h", tag, r, sl,
                             row_addr_q[r][sl], row_hv_q[r][sl], ea[sl], eh[sl]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; hv_in_valid = 1'b0; hv_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (|{hv_in_ready, load_done, write_enable, write_enable_valid, g_im_a, g_pos_a, g_neg_a,
              c_im_a, c_pos_a, c_neg_a, e_im_a, e_pos_a, e_neg_a, g_im_h, g_pos_h, g_neg_h,
              c_im_h, c_pos_h, c_neg_h, e_im_h, e_pos_h, e_neg_h} !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero want all 0");
        end
        @(posedge clk); #1; rst = 1'b0;
        clear_mon();
        hv_in = rand_hv(); hv_in_valid = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        hv_in_valid = 1'b0;
        n_cmp++;
        if (cur_beats !== 0 || wev_cnt !== 0) begin
            n_err++; $display("FAIL idle_no_accept: got beats=%0d wev=%0d want 0/0", cur_beats, wev_cnt);
        end
    endtask

    task automatic test_full_load();
        clear_mon();
        pulse_start();
        drive_beats(TOTAL, 0, 1'b0);
        wait_done("full");
        hv_in_valid = 1'b0;
        check_load("full");
        n_cmp++;
        if (wev_cnt !== TOTAL + EEG_CH + 1) begin
            n_err++; $display("FAIL full_cycles: got %0d want %0d", wev_cnt, TOTAL + EEG_CH + 1);
        end
        @(negedge clk);
        n_cmp++;
        if ({load_done, write_enable, write_enable_valid, hv_in_ready} !== 4'b1000) begin
            n_err++; $display("FAIL done_outputs: got %b want 1000",
                              {load_done, write_enable, write_enable_valid, hv_in_ready});
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        pulse_start();
        n_cmp++;
        if (load_done !== 1'b0) begin n_err++; $display("FAIL b2b_clear: load_done got %b want 0", load_done); end
        drive_beats(TOTAL, 0, 1'b0);
        wait_done("b2b");
        hv_in_valid = 1'b0;
        check_load("b2b");
    endtask

    task automatic test_exhaustion();
        clear_mon();
        pulse_start();
        drive_beats(TOTAL, 3, 1'b0);
        wait_done("exh");
        hv_in_valid = 1'b0;
        check_load("exh");
        for (int r = GSR_CH; r < ECG_CH && r < row_addr_q.size(); r++) begin
            n_cmp++;
            if (row_beats[r] !== 6) begin n_err++; $display("FAIL exh_six r%0d: got %0d want 6", r, row_beats[r]); end
        end
        for (int r = GSR_CH; r < row_addr_q.size(); r++) begin
            n_cmp++;
            if (row_addr_q[r][0] !== 8'(GSR_CH - 1) || row_addr_q[r][1] !== 8'(GSR_CH - 1) ||
                row_addr_q[r][2] !== 8'(GSR_CH - 1)) begin
                n_err++; $display("FAIL exh_gsr_hold r%0d: got %0d want %0d", r, row_addr_q[r][0], GSR_CH - 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int pre = 9 * 3 + 2;  // rows 0..2 are full, then two beats into row 3
        clear_mon();
        pulse_start();
        drive_beats(pre, 0, 1'b0);
        hv_in_valid = 1'b0;
        pulse_start();
        n_cmp++;
        if ({hv_in_ready, load_done} !== 2'b10 || row_addr_q.size() != 3) begin
            n_err++; $display("FAIL start_ignored: got rdy/done=%b rows=%0d want 10 rows=3",
                              {hv_in_ready, load_done}, row_addr_q.size());
        end
        drive_beats(TOTAL - pre, 0, 1'b0);
        wait_done("ign");
        hv_in_valid = 1'b0;
        check_load("ign");
    endtask

    task automatic test_valid_gaps();
        clear_mon();
        pulse_start();
        drive_beats(TOTAL, 279, 1'b0);
        wait_done("gaps");
        hv_in_valid = 1'b0;
        check_load("gaps");
    endtask

`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [15:0] exp_c;
        logic [PADW-1:0] p;
        logic [15:0] held;
        clear_mon();
        pulse_start();
        drive_beats(TOTAL, 0, 1'b1);
        wait_done("cs1");
        hv_in_valid = 1'b0;
        n_cmp++;
        if (checksum !== 16'h0000) begin n_err++; $display("FAIL csum_ones: got %h want 0000", checksum); end
        clear_mon();
        pulse_start();
        drive_beats(TOTAL, 2, 1'b0);
        wait_done("cs2");
        hv_in_valid = 1'b0;
        exp_c = '0;
        foreach (sent[i]) begin
            p = PADW'(sent[i]);
            for (int c = 0; c < PADW / 16; c++) exp_c ^= p[c*16 +: 16];
        end
        held = checksum;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (checksum !== exp_c || held !== exp_c) begin
            n_err++; $display("FAIL csum_rand: got %h/%h want %h", held, checksum, exp_c);
        end
    endtask
`endif

    task automatic test_reset_midload();
        int pre = 9 * GSR_CH + 6 * 2 + 1;  // lands on r=5, s=4 for the 3/6/7 geometry
        int beats_before;
        clear_mon();
        pulse_start();
        drive_beats(pre, 1, 1'b0);
        hv_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (|{hv_in_ready, load_done, write_enable, write_enable_valid, g_im_a, g_pos_a, g_neg_a,
              c_im_a, c_pos_a, c_neg_a, e_im_a, e_pos_a, e_neg_a, g_im_h, g_pos_h, g_neg_h,
              c_im_h, c_pos_h, c_neg_h, e_im_h, e_pos_h, e_neg_h} !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: got nonzero want all 0");
        end
        @(posedge clk); #1; rst = 1'b0;
        beats_before = cur_beats;
        hv_in_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        hv_in_valid = 1'b0;
        n_cmp++;
        if (we_cnt !== 0 || cur_beats !== beats_before || hv_in_ready !== 1'b0 || row_addr_q.size() != 5) begin
            n_err++; $display("FAIL midreset_idle: got we=%0d beats=%0d rdy=%b rows=%0d want 0 %0d 0 5",
                              we_cnt, cur_beats, hv_in_ready, row_addr_q.size(), beats_before);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_back_to_back();
        test_exhaustion();
        test_start_ignored();
        test_valid_gaps();
`ifdef HDC_SRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
